fetch_bundle_sequencer: RTL and testbench

//  Front-end fetch controller between the icache and the dual-decode issue queue.

---
 rtl/fetch_bundle_sequencer.sv | 157 +++++++++++++++
 tb/tb_fetch_bundle_sequencer.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_bundle_sequencer.sv
// Fetch front-end: issues 4-instruction bundle requests to the icache, tags them with a
// redirect epoch, buffers matching responses in a 2-entry FIFO and presents them to the issue queue.
module fetch_bundle_sequencer #(
    parameter int              PC_W     = 64,
    parameter logic [PC_W-1:0] RESET_PC = 64'h8000_0000,
    parameter int              MAX_OUT  = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                j_bad1,
    input  logic [PC_W-1:0]     j_bad1_pc,
    input  logic                j_bad2,
    input  logic [PC_W-1:0]     j_bad2_pc,
    input  logic                trap,
    input  logic [PC_W-1:0]     trap_pc,
    input  logic                fetch_halt,
    output logic                req_valid,
    input  logic                req_ready,
    output logic [PC_W-1:0]     req_pc,
    output logic                req_tag,
    input  logic                resp_valid,
    input  logic                resp_tag,
    input  logic [127:0]        resp_inst,
    output logic                iq_valid,
    input  logic                iq_accept,
    output logic [4*PC_W-1:0]   iq_pc,
    output logic [127:0]        iq_inst,
    output logic [1:0]          outstanding
);

    typedef enum logic [1:0] {BOOT, RUN, HALT, REDIR} state_t;

    state_t            state;
    state_t            state_next;
    logic [PC_W-1:0]   next_pc;
    logic              epoch;
    logic              req_hold;
    logic [1:0]        fifo_count;
    logic              fifo_rd;
    logic              fifo_wr;
    logic [PC_W-1:0]   fifo_pc   [2];
    logic [127:0]      fifo_inst [2];
    logic              pq_rd;
    logic              pq_wr;
    logic [PC_W-1:0]   pq_pc     [2];

    logic              redirect;
    logic [PC_W-1:0]   redirect_pc;
    logic              cap_ok;
    logic              hs;
    logic              resp_keep;
    logic              pop;
    logic [PC_W-1:0]   head_pc;

    assign redirect    = trap | j_bad1 | j_bad2;
    assign redirect_pc = trap ? trap_pc : (j_bad1 ? j_bad1_pc : j_bad2_pc);
    assign cap_ok      = (3'(outstanding) + 3'(fifo_count)) < 3'(MAX_OUT);
    assign hs          = req_valid & req_ready;
    assign resp_keep   = resp_valid & (resp_tag == epoch) & ~redirect;
    assign pop         = iq_valid & iq_accept & ~redirect;
    assign head_pc     = fifo_pc[fifo_rd];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= BOOT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (redirect) begin
            state_next = REDIR;
        end else begin
            unique case (state)
                BOOT:    state_next = RUN;
                RUN:     state_next = fetch_halt ? HALT : RUN;
                HALT:    state_next = fetch_halt ? HALT : RUN;
                REDIR:   state_next = fetch_halt ? HALT : RUN;
                default: state_next = BOOT;
            endcase
        end
    end

    // A request offered but not yet accepted stays up (even into HALT) until a redirect withdraws it.
    always_comb begin
        req_valid = req_hold | ((state == RUN) & cap_ok);
        req_pc    = req_valid ? next_pc : '0;
        req_tag   = req_valid & epoch;
        iq_valid  = (fifo_count != 2'd0);
        iq_inst   = iq_valid ? fifo_inst[fifo_rd] : '0;
        iq_pc     = '0;
        if (iq_valid) begin
            for (int k = 0; k < 4; k++) begin
                iq_pc[PC_W*k +: PC_W] = head_pc + PC_W'(4 * k);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            next_pc     <= RESET_PC;
            epoch       <= 1'b0;
            req_hold    <= 1'b0;
            outstanding <= 2'd0;
            fifo_count  <= 2'd0;
            fifo_rd     <= 1'b0;
            fifo_wr     <= 1'b0;
            pq_rd       <= 1'b0;
            pq_wr       <= 1'b0;
        end else begin
            req_hold    <= req_valid & ~req_ready & ~redirect;
            outstanding <= outstanding + 2'(hs) - 2'(resp_valid);
            if (redirect) begin
                epoch      <= ~epoch;
                next_pc    <= redirect_pc;
                fifo_count <= 2'd0;
                fifo_rd    <= 1'b0;
                fifo_wr    <= 1'b0;
                pq_rd      <= 1'b0;
                pq_wr      <= 1'b0;
            end else begin
                if (hs) begin
                    next_pc <= next_pc + PC_W'(16);
                    pq_wr   <= ~pq_wr;
                end
                // Stale-epoch responses never consume a pc-queue slot; only current ones were queued.
                if (resp_keep) begin
                    fifo_wr <= ~fifo_wr;
                    pq_rd   <= ~pq_rd;
                end
                if (pop) begin
                    fifo_rd <= ~fifo_rd;
                end
                fifo_count <= fifo_count + 2'(resp_keep) - 2'(pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (hs && !redirect) begin
            pq_pc[pq_wr] <= next_pc;
        end
        if (resp_keep) begin
            fifo_pc[fifo_wr]   <= pq_pc[pq_rd];
            fifo_inst[fifo_wr] <= resp_inst;
        end
    end

    resp_needs_request: assert property (@(posedge clk) disable iff (rst)
        !(resp_valid && outstanding == 2'd0));

    outstanding_bounded: assert property (@(posedge clk) disable iff (rst)
        (32'(outstanding) <= MAX_OUT));

endmodule

// File: tb/tb_fetch_bundle_sequencer.sv
// Randomised bench for fetch_bundle_sequencer: an icache model answers requests, a reference
// model predicts request stream and delivered bundles, and a negedge monitor scoreboards them.
module tb_fetch_bundle_sequencer;

    localparam logic [63:0] RESET_PC = 64'h8000_0000;
    localparam int P_BOOT  = 0;
    localparam int P_RUN   = 1;
    localparam int P_HALT  = 2;
    localparam int P_REDIR = 3;

    logic          clk;
    logic          rst;
    logic          j_bad1;
    logic [63:0]   j_bad1_pc;
    logic          j_bad2;
    logic [63:0]   j_bad2_pc;
    logic          trap;
    logic [63:0]   trap_pc;
    logic          fetch_halt;
    logic          req_valid;
    logic          req_ready;
    logic [63:0]   req_pc;
    logic          req_tag;
    logic          resp_valid;
    logic          resp_tag;
    logic [127:0]  resp_inst;
    logic          iq_valid;
    logic          iq_accept;
    logic [255:0]  iq_pc;
    logic [127:0]  iq_inst;
    logic [1:0]    outstanding;

    fetch_bundle_sequencer dut (
        .clk(clk), .rst(rst),
        .j_bad1(j_bad1), .j_bad1_pc(j_bad1_pc),
        .j_bad2(j_bad2), .j_bad2_pc(j_bad2_pc),
        .trap(trap), .trap_pc(trap_pc),
        .fetch_halt(fetch_halt),
        .req_valid(req_valid), .req_ready(req_ready), .req_pc(req_pc), .req_tag(req_tag),
        .resp_valid(resp_valid), .resp_tag(resp_tag), .resp_inst(resp_inst),
        .iq_valid(iq_valid), .iq_accept(iq_accept), .iq_pc(iq_pc), .iq_inst(iq_inst),
        .outstanding(outstanding)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] pc;
        logic        tag;
        int          due;
    } ic_t;

    typedef struct {
        logic [63:0]  pc;
        logic [127:0] inst;
    } bundle_t;

    ic_t         ic_q[$];
    bundle_t     sb[$];
    bundle_t     pp;
    logic        pp_valid;

    logic [63:0] m_pc;
    logic        m_epoch;
    int          m_inflight;
    int          m_phase;
    logic        m_pend;

    int n_checks;
    int n_fail;
    int cyc;
    int last_due;
    int since_redir;
    int ready_pct;
    int accept_pct;
    int halt_pct;
    int redir_pct;
    int lat_extra;

    logic        f_trap;
    logic        f_jb1;
    logic        f_jb2;
    logic [63:0] f_trap_pc;
    logic [63:0] f_jb1_pc;
    logic [63:0] f_jb2_pc;

    function automatic void check_output(string name, logic [255:0] act, logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic logic [63:0] rand_target();
        logic [63:0] t;
        if ($urandom_range(3) == 0) begin
            t = 64'hFFFF_FFFF_FFFF_FFE0;
        end else begin
            t = {$urandom, $urandom} & ~64'h3;
        end
        return t;
    endfunction

    task automatic reset_model();
        m_pc        = RESET_PC;
        m_epoch     = 1'b0;
        m_inflight  = 0;
        m_phase     = P_BOOT;
        m_pend      = 1'b0;
        ic_q.delete();
        sb.delete();
        pp_valid    = 1'b0;
        last_due    = 0;
        since_redir = 0;
    endtask

    task automatic clear_inputs();
        {j_bad1, j_bad2, trap, fetch_halt, req_ready, resp_valid, resp_tag, iq_accept} = '0;
        j_bad1_pc = '0;
        j_bad2_pc = '0;
        trap_pc   = '0;
        resp_inst = '0;
    endtask

    task automatic check_reset_outputs();
        check_output("rst_req_valid", req_valid, 0);
        check_output("rst_req_pc", req_pc, 0);
        check_output("rst_req_tag", req_tag, 0);
        check_output("rst_iq_valid", iq_valid, 0);
        check_output("rst_iq_pc", iq_pc, 0);
        check_output("rst_iq_inst", iq_inst, 0);
        check_output("rst_outstanding", outstanding, 0);
    endtask

    // One clock of stimulus: commits last cycle's accepted response, then drives this cycle's inputs.
    task automatic apply_stimulus();
        ic_t  e;
        logic redir_now;
        @(posedge clk);
        #1;
        if (pp_valid) sb.push_back(pp);
        pp_valid = 1'b0;
        cyc++;
        since_redir++;
        req_ready = ($urandom_range(99) < ready_pct);
        iq_accept = ($urandom_range(99) < accept_pct);
        if (halt_pct == 0) fetch_halt = 1'b0;
        else if ($urandom_range(99) < halt_pct) fetch_halt = ~fetch_halt;
        trap = 1'b0;
        j_bad1 = 1'b0;
        j_bad2 = 1'b0;
        if (f_trap || f_jb1 || f_jb2) begin
            trap = f_trap;
            j_bad1 = f_jb1;
            j_bad2 = f_jb2;
            trap_pc = f_trap_pc;
            j_bad1_pc = f_jb1_pc;
            j_bad2_pc = f_jb2_pc;
            {f_trap, f_jb1, f_jb2} = '0;
            since_redir = 0;
        end else if (since_redir > 12 && $urandom_range(99) < redir_pct) begin
            {trap, j_bad1, j_bad2} = 3'($urandom_range(7, 1));
            trap_pc = rand_target();
            j_bad1_pc = rand_target();
            j_bad2_pc = rand_target();
            since_redir = 0;
        end
        redir_now = trap | j_bad1 | j_bad2;
        resp_valid = 1'b0;
        resp_tag = 1'b0;
        resp_inst = '0;
        if (ic_q.size() > 0 && ic_q[0].due <= cyc) begin
            e = ic_q.pop_front();
            resp_valid = 1'b1;
            resp_tag = e.tag;
            resp_inst = {$urandom, $urandom, $urandom, $urandom};
            if (e.tag == m_epoch && !redir_now) begin
                pp_valid = 1'b1;
                pp.pc = e.pc;
                pp.inst = resp_inst;
            end
        end
    endtask

    // Monitor: at negedge the inputs for the coming edge are settled, so compare and advance the model.
    always @(negedge clk) begin
        logic         exp_rv;
        logic         redir;
        logic [255:0] exp_pcs;
        ic_t          n;
        int           d;
        if (!rst) begin
            exp_rv = m_pend || (m_phase == P_RUN && (m_inflight + sb.size()) < 2);
            check_output("req_valid", req_valid, exp_rv);
            check_output("req_pc", req_pc, exp_rv ? m_pc : 64'd0);
            check_output("req_tag", req_tag, exp_rv ? m_epoch : 1'b0);
            check_output("outstanding", outstanding, m_inflight);
            check_output("iq_valid", iq_valid, sb.size() != 0);
            exp_pcs = '0;
            if (sb.size() != 0) begin
                for (int k = 0; k < 4; k++) exp_pcs[64*k +: 64] = sb[0].pc + 64'(4 * k);
                check_output("iq_inst", iq_inst, sb[0].inst);
            end else begin
                check_output("iq_inst", iq_inst, 0);
            end
            check_output("iq_pc", iq_pc, exp_pcs);

            redir = trap | j_bad1 | j_bad2;
            if (exp_rv && req_ready) begin
                d = cyc + 2 + $urandom_range(lat_extra);
                if (d <= last_due) d = last_due + 1;
                last_due = d;
                n.pc = m_pc;
                n.tag = m_epoch;
                n.due = d;
                ic_q.push_back(n);
                m_inflight++;
                m_pc = m_pc + 64'd16;
            end
            if (resp_valid) m_inflight--;
            if (sb.size() != 0 && iq_accept && !redir) void'(sb.pop_front());
            if (redir) begin
                m_epoch = ~m_epoch;
                m_pc = trap ? trap_pc : (j_bad1 ? j_bad1_pc : j_bad2_pc);
                sb.delete();
                m_pend = 1'b0;
                m_phase = P_REDIR;
            end else begin
                m_pend = exp_rv && !req_ready;
                m_phase = (m_phase == P_BOOT) ? P_RUN : (fetch_halt ? P_HALT : P_RUN);
            end
        end
    end

    task automatic wait_req_valid(string name, logic [63:0] target);
        for (int i = 0; i < 10; i++) begin
            apply_stimulus();
            if (req_valid) break;
        end
        check_output({name, "_req_pc"}, req_pc, target);
        check_output({name, "_req_tag"}, req_tag, m_epoch);
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        cyc = 0;
        {f_trap, f_jb1, f_jb2} = '0;
        f_trap_pc = '0;
        f_jb1_pc = '0;
        f_jb2_pc = '0;
        clear_inputs();
        reset_model();
        rst = 1'b1;
        #2;
        check_reset_outputs();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        ready_pct = 100; accept_pct = 100; halt_pct = 0; redir_pct = 0; lat_extra = 0;
        repeat (20) apply_stimulus();

        accept_pct = 0;
        repeat (15) apply_stimulus();
        accept_pct = 100;
        repeat (15) apply_stimulus();

        lat_extra = 3;
        for (int i = 0; i < 30; i++) begin
            if (outstanding == 2'd2) break;
            apply_stimulus();
        end
        check_output("two_in_flight", outstanding, 2);
        f_jb2 = 1'b1;
        f_jb2_pc = 64'h8000_1000;
        apply_stimulus();
        wait_req_valid("jbad2", 64'h8000_1000);

        lat_extra = 0;
        repeat (12) apply_stimulus();
        f_trap = 1'b1;
        f_trap_pc = 64'h8000_0100;
        f_jb1 = 1'b1;
        f_jb1_pc = 64'h8000_0200;
        apply_stimulus();
        wait_req_valid("trap_prio", 64'h8000_0100);

        ready_pct = 0; halt_pct = 40;
        repeat (12) apply_stimulus();
        ready_pct = 100; halt_pct = 0;
        repeat (10) apply_stimulus();

        ready_pct = 70; accept_pct = 70; halt_pct = 10; redir_pct = 5; lat_extra = 2;
        repeat (600) apply_stimulus();

        ready_pct = 100; accept_pct = 100; halt_pct = 0; redir_pct = 0; lat_extra = 0;
        repeat (14) apply_stimulus();
        for (int i = 0; i < 20; i++) begin
            apply_stimulus();
            if (resp_valid) break;
        end
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs();
        clear_inputs();
        reset_model();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        wait_req_valid("post_reset", RESET_PC);

        ready_pct = 80; accept_pct = 60; halt_pct = 8; redir_pct = 4; lat_extra = 1;
        repeat (200) apply_stimulus();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
